cnn_conv_stream: RTL

//  Parametrised successor of the fixed 3x3/4-kernel CNN top. Streams one frame of IMG_W x IMG_H

---
 rtl/cnn_pkg.sv | 17 +
 rtl/cnn_linebuf_3x3.sv | 79 +++++++
 rtl/cnn_conv_stream.sv | 123 ++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared constants and types for the streaming 3x3 convolution block.
package cnn_pkg;
    localparam int WI_DEF   = 8;
    localparam int WW_DEF   = 8;
    localparam int ACCW_DEF = 32;
    localparam int TAPS     = 9;
    localparam int BIAS_IDX = 9;
    localparam int KSLOTS   = TAPS + 1;   // weight RAM words per kernel

    function automatic int prod_width(input int wi, input int ww);
        return wi + ww + 1;
    endfunction

    localparam int PROD_W = prod_width(WI_DEF, WW_DEF);

    typedef logic [WI_DEF-1:0] window_t [3][3];
endpackage

// File: rtl/cnn_linebuf_3x3.sv
// Raster line buffers, row/col counters and 3x3 sliding window.
// Flags the accepted pixel that completes a full window, and the last window of the frame.
module cnn_linebuf_3x3
    import cnn_pkg::*;
#(
    parameter int WI    = WI_DEF,
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               en,
    input  logic               accept,
    input  logic [WI-1:0]      pixel,
    output logic [TAPS*WI-1:0] window,
    output logic               win_valid,
    output logic               win_last
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [WI-1:0] lb0 [IMG_W];   // previous row
    logic [WI-1:0] lb1 [IMG_W];   // two rows back
    logic [WI-1:0] win [3][3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col       <= '0;
            row       <= '0;
            win_valid <= 1'b0;
            win_last  <= 1'b0;
        end else if (clear) begin
            col       <= '0;
            row       <= '0;
            win_valid <= 1'b0;
            win_last  <= 1'b0;
        end else begin
            if (accept) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
            if (en) begin
                win_valid <= accept && (row >= RW'(2)) && (col >= CW'(2));
                win_last  <= accept && (row == ROW_LAST) && (col == COL_LAST);
            end
        end
    end

    // NOTE: line buffers and window are datapath storage qualified by win_valid, so they need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= lb1[col];
            win[1][2] <= lb0[col];
            win[2][2] <= pixel;
            lb1[col]  <= lb0[col];
            lb0[col]  <= pixel;
        end
    end

    always_comb begin
        window = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                window[(r*3 + c)*WI +: WI] = win[r][c];
    end
endmodule

// File: rtl/cnn_conv_stream.sv
// Streaming 3x3 convolution of an IMG_W x IMG_H frame with NK runtime-loaded signed kernels.
// Build option: define CNN_RELU_EN to clamp negative channel sums to zero at the output register.
module cnn_conv_stream
    import cnn_pkg::*;
#(
    parameter int WI    = WI_DEF,
    parameter int WW    = WW_DEF,
    parameter int ACCW  = ACCW_DEF,
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int NK    = 4
) (
    input  logic                          iClk,
    input  logic                          iRsn,
    input  logic                          iClear,
    input  logic [WI-1:0]                 iPixelIn,
    input  logic                          iPixelValid,
    output logic                          oPixelReady,
    input  logic                          iWgtWe,
    input  logic [$clog2(NK*KSLOTS)-1:0]  iWgtAddr,
    input  logic [WW-1:0]                 iWgtData,
    output logic                          oValid,
    input  logic                          iReady,
    output logic [NK*ACCW-1:0]            oData,
    output logic                          oFrameDone,
    output logic                          oBusy
);
    localparam int PW = prod_width(WI, WW);
    localparam int NW = NK * KSLOTS;

    logic                     en, accept, handoff;
    logic [TAPS*WI-1:0]       window;
    logic                     win_valid, win_last;
    logic signed [WW-1:0]     wgt [NW];
    logic [NK*ACCW-1:0]       mac_flat, s1_flat;
    logic                     s1_valid, s1_last, out_last;

    // The whole pipeline advances together; a held output freezes everything upstream.
    assign en          = ~oValid | iReady;
    assign oPixelReady = en & ~iClear;
    assign accept      = iPixelValid & oPixelReady;
    assign handoff     = oValid & iReady;

    cnn_linebuf_3x3 #(.WI(WI), .IMG_W(IMG_W), .IMG_H(IMG_H)) u_linebuf (
        .clk       (iClk),
        .rst_n     (iRsn),
        .clear     (iClear),
        .en        (en),
        .accept    (accept),
        .pixel     (iPixelIn),
        .window    (window),
        .win_valid (win_valid),
        .win_last  (win_last)
    );

    // Kernels may only change between frames so a frame never mixes two weight sets.
    always_ff @(posedge iClk) begin
        if (iWgtWe && !oBusy && (int'(iWgtAddr) < NW))
            wgt[iWgtAddr] <= iWgtData;
    end

    for (genvar k = 0; k < NK; k++) begin : g_mac
        logic signed [ACCW-1:0] sum;

        always_comb begin
            logic signed [PW-1:0] prod;
            prod = '0;
            sum  = ACCW'(wgt[k*KSLOTS + BIAS_IDX]);
            for (int i = 0; i < TAPS; i++) begin
                prod = PW'($signed({1'b0, window[i*WI +: WI]})) * PW'(wgt[k*KSLOTS + i]);
                sum  = sum + ACCW'(prod);
            end
        end

        assign mac_flat[k*ACCW +: ACCW] = sum;
    end

    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            s1_valid   <= 1'b0;
            s1_last    <= 1'b0;
            s1_flat    <= '0;
            oValid     <= 1'b0;
            out_last   <= 1'b0;
            oData      <= '0;
            oFrameDone <= 1'b0;
            oBusy      <= 1'b0;
        end else if (iClear) begin
            s1_valid   <= 1'b0;
            s1_last    <= 1'b0;
            s1_flat    <= '0;
            oValid     <= 1'b0;
            out_last   <= 1'b0;
            oData      <= '0;
            oFrameDone <= 1'b0;
            oBusy      <= 1'b0;
        end else begin
            if (en) begin
                s1_valid <= win_valid;
                s1_last  <= win_last;
                if (win_valid)
                    s1_flat <= mac_flat;
                oValid   <= s1_valid;
                out_last <= s1_last;
                if (s1_valid) begin
                    for (int k = 0; k < NK; k++) begin
`ifdef CNN_RELU_EN
                        oData[k*ACCW +: ACCW] <= s1_flat[k*ACCW + ACCW - 1] ? '0 : s1_flat[k*ACCW +: ACCW];
`else
                        oData[k*ACCW +: ACCW] <= s1_flat[k*ACCW +: ACCW];
`endif
                    end
                end
            end
            oFrameDone <= handoff & out_last;
            // A first pixel of the next frame wins over the end of the current one.
            if (accept)
                oBusy <= 1'b1;
            else if (handoff && out_last)
                oBusy <= 1'b0;
        end
    end
endmodule
